// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the asynchronous-SRAM front-end.
//   state_e  : controller FSM states
//   *_DEF    : default geometry and timing (cycles at a 10 ns clock)
//   cnt_w()  : width of a down-counter that must hold max(cycle counts)-1
//   CNT_W    : that width for the default timing
// Optional feature: SRAM_CTRL_STATS_EN (read/write counters in sram_ctrl).
package sram_ctrl_pkg;

  localparam int AW_DEF       = 12;
  localparam int DW_DEF       = 8;
  localparam int RD_WAIT_DEF  = 2;
  localparam int WR_PULSE_DEF = 2;
  localparam int TURN_DEF     = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_TURN,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_e;

  // The counter is loaded with N-1, so clog2(max) bits suffice (min 1).
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_w(RD_WAIT_DEF, WR_PULSE_DEF, TURN_DEF);

endpackage

// File: rtl/sram_ctrl_io.sv
// Data-bus side of the SRAM front-end.
//   ld_wdata/wdata : load the write-data register (on request accept)
//   oe_d           : next-cycle bus drive enable; registered into oe
//   cap            : sample dbus into rdata at this edge
//   dbus           : SRAM data bus, driven from wdata_q only while oe
//   oe             : registered drive enable (observable internal state)
//   rdata          : captured read data, held until the next capture
module sram_ctrl_io #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_wdata,
  input  logic [DW-1:0] wdata,
  input  logic          oe_d,
  input  logic          cap,
  inout  wire  [DW-1:0] dbus,
  output logic          oe,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata_q <= '0;
      oe      <= 1'b0;
      rdata   <= '0;
    end else begin
      if (ld_wdata) wdata_q <= wdata;
      oe <= oe_d;
      if (cap) rdata <= dbus;
    end
  end

  assign dbus = oe ? wdata_q : 'z;

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous valid/ready front-end for a 4K x 8 asynchronous SRAM.
// Sequences CSB/WRB, address setup, write-data drive window, read capture
// and post-read bus turnaround. All SRAM pins come straight from flops.
//   clk, rst                 : clock, async active-high reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata: request payload (1 = write)
//   rsp_valid/rsp_rdata      : one-cycle read-data pulse, data held after
//   busy                     : FSM not in IDLE
//   csb, wrb, abus, dbus     : SRAM pins
//   rd_cnt, wr_cnt           : only with SRAM_CTRL_STATS_EN defined
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int RD_WAIT_CYC  = RD_WAIT_DEF,
  parameter int WR_PULSE_CYC = WR_PULSE_DEF,
  parameter int TURN_CYC     = TURN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
`ifdef SRAM_CTRL_STATS_EN
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt,
`endif
  output logic          csb,
  output logic          wrb,
  output logic [AW-1:0] abus,
  inout  wire  [DW-1:0] dbus
);

  localparam int CW = cnt_w(RD_WAIT_CYC, WR_PULSE_CYC, TURN_CYC);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, cap, oe_d, dbus_oe;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = req_we ? ST_WR_SETUP : ST_RD_WAIT;
          cnt_d   = req_we ? '0 : CW'(RD_WAIT_CYC - 1);
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_TURN;
          cnt_d   = CW'(TURN_CYC - 1);
          cap     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = CW'(WR_PULSE_CYC - 1);
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WR_HOLD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Bus stays released for the first WRB-low cycle while the SRAM turns
    // its outputs off; drive from the second pulse cycle through the hold.
    oe_d = ((state_q == ST_WR_PULSE) && (state_d == ST_WR_PULSE)) ||
           (state_d == ST_WR_HOLD);
  end

  // Pin flops follow the next state so each pin lines up with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      csb       <= 1'b1;
      wrb       <= 1'b1;
      abus      <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      csb       <= (state_d == ST_IDLE) || (state_d == ST_TURN);
      wrb       <= (state_d != ST_WR_PULSE);
      rsp_valid <= cap;
      if (accept) abus <= req_addr;
    end
  end

  sram_ctrl_io #(.DW(DW)) u_io (
    .clk      (clk),
    .rst      (rst),
    .ld_wdata (accept),
    .wdata    (req_wdata),
    .oe_d     (oe_d),
    .cap      (cap),
    .dbus     (dbus),
    .oe       (dbus_oe),
    .rdata    (rsp_rdata)
  );

`ifdef SRAM_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rsp_valid)               rd_cnt <= rd_cnt + 16'd1;
      if (state_q == ST_WR_HOLD)   wr_cnt <= wr_cnt + 16'd1;
    end
  end
`endif

endmodule
